nes_controller_responder: RTL and testbench
===========================================

Name: nes_controller_responder

Overview:
- Device-side model of an NES controller (4021-style parallel-in/serial-out shift register).
- Receives latch and clock pulses from an NES host, captures an 8-button snapshot, and shifts it out serially on the data line.
- Used as a stand-in controller for bench/FPGA bring-up of the pong host reader, or to drive a real console from on-chip button sources.
- Sits between the board-level button sources and the NES connector pins (latch, clock in; data out).

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchroniser (legal 2..4).
- IDLE_LEVEL, 1, nes_data level after all 8 bits are shifted out and after reset.

Ports:
- clk  input  1  system clock (25.175 MHz in the pong build).
- reset  input  1  synchronous, active-high reset.
- buttons  input  8  live button state, 1 = pressed; [7]=A [6]=B [5]=Select [4]=Start [3]=Up [2]=Down [1]=Left [0]=Right.
- nes_latch  input  1  host latch pin, asynchronous to clk, active-high.
- nes_clk  input  1  host shift-clock pin, asynchronous to clk; shift on rising edge.
- nes_data  output  1  serial data to host, active-low (0 = pressed).
- bit_index  output  4  bits already shifted in the current frame: 0..8.
- frame_done  output  1  one-cycle pulse when the 8th shift completes.

Behaviour:
- Synchronisers:
  - nes_latch and nes_clk each pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - A rising edge is recognised in the cycle after the last sync stage changes.
  - All state updates occur SYNC_STAGES+1 clk edges after the pin is first sampled high (3 edges at default).
- Storage: 8-bit shift register sr. nes_data is driven combinationally from sr[7] or the idle level (no extra register).
- State machine IDLE / LOADED / SHIFTING / DONE:
  - IDLE (after reset):
    - nes_data = IDLE_LEVEL, bit_index = 0, sr = 8'hFF.
  - Synchronised latch high, in any state: sr <= ~buttons every cycle (continuous parallel load), bit_index <= 0, state <= LOADED. Clock edges are ignored while latch is high.
  - LOADED: nes_data = sr[7], i.e. the A bit is visible as soon as the load occurs.
  - First clock rising edge with latch low in LOADED → SHIFTING; on every qualifying edge:
    - sr <= {sr[6:0], 1'b1}
    - bit_index += 1
  - SHIFTING: nes_data = sr[7]. The edge that brings bit_index to 8 → DONE and asserts frame_done for exactly one cycle, on the same cycle bit_index becomes 8.
  - DONE: nes_data = IDLE_LEVEL. Extra clock edges are ignored; bit_index saturates at 8; no further frame_done.
  - A latch rising edge mid-frame (LOADED/SHIFTING/DONE) aborts and reloads; no frame_done for the aborted frame.
  - No latch after DONE: remain in DONE indefinitely.
- Simultaneous latch high and clock edge in the same synchronised cycle: latch wins, load only, no shift.
- Changes on buttons after the latch falls do not affect the frame in progress.
- Reset at any time returns to IDLE with the values above on the next clk edge. Synchroniser and edge flops clear to 0, so a pin already high at reset release is seen as a rising edge.
- Bit order on nes_data: A, B, Select, Start, Up, Down, Left, Right. This matches the host's reads 1..8.

Test Plan:
- Reset with buttons=8'hFF, pins low → nes_data=1, bit_index=0, frame_done=0 held for 20 cycles.
- buttons=8'b1001_0100 (A, Start, Down); latch pulse of 300 cycles, then 8 clock pulses (150 high/150 low) → nes_data sampled before each clock reads 0,1,1,0,1,0,1,1. After the 8th edge: frame_done pulses once, bit_index=8, nes_data=1.
- Latch held high while 3 clock pulses are applied, buttons=8'h80 → no shift; nes_data stays 0 (A) and bit_index stays 0 after latch falls.
- Mid-frame relatch: 4 shifts done, buttons changed to 8'h01, new latch → bit_index=0, no frame_done; the Right bit is 0 on the 8th read of the new frame.
- 12 clock pulses after one latch → exactly one frame_done; nes_data=1 and bit_index=8 after the 8th edge.
- Assert reset after 5 shifts → next cycle IDLE (nes_data=1, bit_index=0); a following full frame reads correctly.

Source files
------------

// File: rtl/nes_controller_responder_if.sv
// rtl/nes_controller_responder_if.sv - NES controller pin and button bundle
interface nes_controller_responder_if;
   logic [7:0] buttons;
   logic       nes_latch;
   logic       nes_clk;
   logic       nes_data;
   logic [3:0] bit_index;
   logic       frame_done;

   // Host side: drives buttons and connector pins, observes serial data and status
   modport master (
      output buttons,
      output nes_latch,
      output nes_clk,
      input  nes_data,
      input  bit_index,
      input  frame_done
   );

   // Device side: the controller model
   modport slave (
      input  buttons,
      input  nes_latch,
      input  nes_clk,
      output nes_data,
      output bit_index,
      output frame_done
   );
endinterface

// File: rtl/nes_controller_responder.sv
// rtl/nes_controller_responder.sv - 4021-style NES controller device model
module nes_controller_responder #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input logic                   clk,
   input logic                   reset,
   nes_controller_responder_if.slave bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOADED   = 2'd1;
   localparam logic [1:0] ST_SHIFTING = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   logic [SYNC_STAGES-1:0] latch_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic                   clk_d;
   logic                   latch_s;
   logic                   clk_s;
   logic                   clk_rise;

   logic [1:0] state;
   logic [7:0] sr;
   logic [3:0] bit_index_q;
   logic       frame_done_q;

   // Bring the asynchronous host pins into the clk domain; clearing to 0 makes
   // a pin already high at reset release look like a fresh rising edge
   always_ff @(posedge clk) begin
      if (reset) begin
         latch_sync <= '0;
         clk_sync   <= '0;
         clk_d      <= 1'b0;
      end else begin
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.nes_latch};
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], bus.nes_clk};
         clk_d      <= clk_s;
      end
   end

   assign latch_s  = latch_sync[SYNC_STAGES-1];
   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_d;

   // Frame sequencing: latch level reloads continuously and overrides any shift;
   // shift edges only count while a loaded frame is in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         sr           <= 8'hFF;
         bit_index_q  <= 4'd0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (latch_s) begin
            sr          <= ~bus.buttons;
            bit_index_q <= 4'd0;
            state       <= ST_LOADED;
         end else if (clk_rise && (state == ST_LOADED || state == ST_SHIFTING)) begin
            sr          <= {sr[6:0], 1'b1};
            bit_index_q <= bit_index_q + 4'd1;
            if (bit_index_q == 4'd7) begin
               state        <= ST_DONE;
               frame_done_q <= 1'b1;
            end else begin
               state <= ST_SHIFTING;
            end
         end
      end
   end

   // Serial data straight from the register head while a frame is live
   always_comb begin
      bus.nes_data = IDLE_LEVEL;
      if (state == ST_LOADED || state == ST_SHIFTING) begin
         bus.nes_data = sr[7];
      end
   end

   assign bus.bit_index  = bit_index_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// tb/tb_nes_controller_responder.sv - directed table bench for nes_controller_responder
module tb_nes_controller_responder;

   typedef struct {
      logic [7:0] buttons;
      logic [7:0] exp_reads;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   fd_count;

   nes_controller_responder_if bus ();

   nes_controller_responder #(
      .SYNC_STAGES (2),
      .IDLE_LEVEL  (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Count every cycle frame_done is high; bit_index must read 8 on that cycle
   always @(negedge clk) begin
      if (!reset && bus.frame_done === 1'b1) begin
         fd_count++;
         check("fd_with_index8", 32'(bus.bit_index), 32'd8);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic latch_pulse(input int len);
      bus.nes_latch = 1'b1;
      tick(len);
      bus.nes_latch = 1'b0;
      tick(6);
   endtask

   task automatic clk_pulse(input int hi, input int lo);
      bus.nes_clk = 1'b1;
      tick(hi);
      bus.nes_clk = 1'b0;
      tick(lo);
   endtask

   // Latch a snapshot, scramble the buttons afterwards, read 8 bits before each clock
   task automatic run_frame(input logic [7:0] btn, input int lat, input int hi, input int lo,
                            output logic [7:0] reads, output int fd_delta);
      int base;
      base = fd_count;
      bus.buttons = btn;
      latch_pulse(lat);
      bus.buttons = ~btn ^ 8'h5A;
      reads = 8'h00;
      for (int k = 0; k < 8; k++) begin
         reads = {reads[6:0], bus.nes_data};
         clk_pulse(hi, lo);
      end
      fd_delta = fd_count - base;
   endtask

   vec_t vecs[6];

   initial begin
      logic [7:0] reads;
      int         fdd;
      int         bad;
      int         base;

      checks   = 0;
      errors   = 0;
      fd_count = 0;

      vecs[0] = '{buttons: 8'h00, exp_reads: 8'hFF};
      vecs[1] = '{buttons: 8'hFF, exp_reads: 8'h00};
      vecs[2] = '{buttons: 8'h80, exp_reads: 8'h7F};
      vecs[3] = '{buttons: 8'h01, exp_reads: 8'hFE};
      vecs[4] = '{buttons: 8'hA5, exp_reads: 8'h5A};
      vecs[5] = '{buttons: 8'h3C, exp_reads: 8'hC3};

      // Reset held 20 cycles with all buttons pressed and pins low
      reset         = 1'b1;
      bus.buttons   = 8'hFF;
      bus.nes_latch = 1'b0;
      bus.nes_clk   = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bus.nes_data !== 1'b1 || bus.bit_index !== 4'd0 || bus.frame_done !== 1'b0) bad++;
      end
      check("reset_hold_bad_cycles", 32'(bad), 32'd0);
      check("reset_nes_data", 32'(bus.nes_data), 32'd1);
      check("reset_bit_index", 32'(bus.bit_index), 32'd0);
      check("reset_frame_done", 32'(bus.frame_done), 32'd0);
      reset = 1'b0;
      tick(5);
      check("idle_nes_data", 32'(bus.nes_data), 32'd1);

      // Main frame: A, Start, Down pressed, slow host timing
      run_frame(8'b1001_0100, 300, 150, 150, reads, fdd);
      check("main_reads", 32'(reads), 32'b0110_1011);
      check("main_frame_done_count", 32'(fdd), 32'd1);
      check("main_bit_index", 32'(bus.bit_index), 32'd8);
      check("main_nes_data_idle", 32'(bus.nes_data), 32'd1);

      // Table of button patterns with a faster host
      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].buttons, 8, 6, 6, reads, fdd);
         check($sformatf("vec%0d_reads", v), 32'(reads), 32'(vecs[v].exp_reads));
         check($sformatf("vec%0d_fd", v), 32'(fdd), 32'd1);
         check($sformatf("vec%0d_idx", v), 32'(bus.bit_index), 32'd8);
      end

      // Clock pulses while latch is held are ignored
      bus.buttons   = 8'h80;
      bus.nes_latch = 1'b1;
      tick(8);
      for (int k = 0; k < 3; k++) clk_pulse(8, 8);
      bus.nes_latch = 1'b0;
      tick(8);
      check("latch_held_nes_data", 32'(bus.nes_data), 32'd0);
      check("latch_held_bit_index", 32'(bus.bit_index), 32'd0);

      // Mid-frame relatch aborts without frame_done
      base = fd_count;
      bus.buttons = 8'h00;
      latch_pulse(8);
      for (int k = 0; k < 4; k++) clk_pulse(6, 6);
      check("relatch_mid_index", 32'(bus.bit_index), 32'd4);
      bus.buttons = 8'h01;
      latch_pulse(8);
      check("relatch_bit_index", 32'(bus.bit_index), 32'd0);
      check("relatch_no_fd", 32'(fd_count - base), 32'd0);
      reads = 8'h00;
      for (int k = 0; k < 8; k++) begin
         reads = {reads[6:0], bus.nes_data};
         clk_pulse(6, 6);
      end
      check("relatch_reads", 32'(reads), 32'hFE);
      check("relatch_fd_total", 32'(fd_count - base), 32'd1);

      // Twelve pulses after one latch: saturation and a single frame_done
      base = fd_count;
      bus.buttons = 8'h42;
      latch_pulse(8);
      for (int k = 0; k < 8; k++) clk_pulse(6, 6);
      check("sat8_nes_data", 32'(bus.nes_data), 32'd1);
      check("sat8_bit_index", 32'(bus.bit_index), 32'd8);
      for (int k = 0; k < 4; k++) clk_pulse(6, 6);
      check("sat12_bit_index", 32'(bus.bit_index), 32'd8);
      check("sat12_nes_data", 32'(bus.nes_data), 32'd1);
      check("sat12_fd_count", 32'(fd_count - base), 32'd1);

      // Reset after 5 shifts, then a clean frame
      base = fd_count;
      bus.buttons = 8'hFF;
      latch_pulse(8);
      for (int k = 0; k < 5; k++) clk_pulse(6, 6);
      check("pre_reset_index", 32'(bus.bit_index), 32'd5);
      reset = 1'b1;
      tick(1);
      check("midreset_nes_data", 32'(bus.nes_data), 32'd1);
      check("midreset_bit_index", 32'(bus.bit_index), 32'd0);
      reset = 1'b0;
      tick(4);
      check("midreset_no_fd", 32'(fd_count - base), 32'd0);
      run_frame(8'h5A, 8, 6, 6, reads, fdd);
      check("post_reset_reads", 32'(reads), 32'hA5);
      check("post_reset_fd", 32'(fdd), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
